fetch_sequencer: RTL and testbench

- Owns the architectural fetch PC and sequences instruction-memory requests for the IF stage.
- Selects next PC from three sources: sequential (PC+4), redirect from EX (branch/jump target), or reset vector.
- Holds at most one outstanding imem transaction.
- Presents fetched instructions to the IF/ID register through a valid/ready handshake, honouring downstream stalls and redirect flushes.

---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC and keeps at most one imem request in flight.
// Latency: one instruction per 3 cycles with 1-cycle memory; if_ready low holds the buffered instruction and stops further requests.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  typedef enum logic [2:0] {REQ, WAIT, HOLD, DRAIN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        outstanding;
  logic        fire;
  logic        pend_next;
  logic        misaligned;

  assign imem_addr  = pc;
  assign fire       = imem_req && imem_gnt;
  // A granted request stays owed until its response shows up, whatever the FSM does meanwhile.
  assign pend_next  = fire || (outstanding && !imem_rvalid);
  assign misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      state        <= pend_next ? DRAIN : REQ;
      outstanding  <= pend_next;
      imem_req     <= 1'b0;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
      if_pc        <= 32'h0;
      if_pc_plus4  <= 32'h0;
      if_instr     <= 32'h0;
    end else begin
      outstanding  <= pend_next;
      misalign_err <= 1'b0;
      if (redirect_valid && state != HALT) begin
        if_valid <= 1'b0;
        if (misaligned) begin
          misalign_err <= 1'b1;
          imem_req     <= 1'b0;
          state        <= HALT;
        end else begin
          pc <= redirect_target;
          if (pend_next) begin
            imem_req <= 1'b0;
            state    <= DRAIN;
          end else begin
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end
      end else begin
        case (state)
          REQ: begin
            // imem_req is low for one cycle after reset; a gnt then is not a handshake.
            if (!imem_req) begin
              imem_req <= 1'b1;
            end else if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if_instr    <= imem_rdata;
              if_pc       <= pc;
              if_pc_plus4 <= pc + PC_STEP;
              if_valid    <= 1'b1;
              pc          <= pc + PC_STEP;
              state       <= HOLD;
            end
          end
          HOLD: begin
            if (if_ready) begin
              if_valid <= 1'b0;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
          DRAIN: begin
            if (imem_rvalid) begin
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
          HALT: begin
            imem_req <= 1'b0;
            if_valid <= 1'b0;
          end
          default: begin
            imem_req <= 1'b0;
            state    <= REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a responding imem model plus an address-level reference of the expected fetch stream.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(RV), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .misalign_err(misalign_err)
  );

  int nchk = 0;
  int nerr = 0;

  // reference state: next PC the program should see, plus halt/pulse/reset expectations
  logic [31:0] model_pc = RV;
  bit          halted = 0, exp_mis = 0, exp_reset = 0, hold_prev = 0;
  logic [31:0] prev_pc, prev_instr;
  // memory state
  bit          busy = 0;
  logic [31:0] mem_addr = 0;
  int          cnt = 0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  bit          rdy_rand = 0;
  int          ngnt = 0, ndeliv = 0;
  logic [31:0] last_gnt = 0, last_pc = 0, last_plus4 = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: check what is visible, drive the next edge's inputs, advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt, input bit rs);
    if (exp_reset) begin
      chk("reset_req", {31'h0, imem_req}, 32'h0);
      chk("reset_valid", {31'h0, if_valid}, 32'h0);
      chk("reset_if_pc", if_pc, 32'h0);
      chk("reset_if_instr", if_instr, 32'h0);
      chk("reset_plus4", if_pc_plus4, 32'h0);
      exp_reset = 0;
    end
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
    exp_mis = 0;
    if (halted) begin
      chk("halt_req", {31'h0, imem_req}, 32'h0);
      chk("halt_valid", {31'h0, if_valid}, 32'h0);
    end
    if (if_valid) chk("no_prefetch", {31'h0, imem_req}, 32'h0);
    if (busy) chk("one_outstanding", {31'h0, imem_req}, 32'h0);
    if (hold_prev) begin
      chk("hold_valid", {31'h0, if_valid}, 32'h1);
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_instr", if_instr, prev_instr);
    end

    rst             = rs;
    redirect_valid  = redir;
    redirect_target = tgt;
    if (rdy_rand) if_ready = (($urandom % 100) < 75);
    imem_gnt    = !rs && imem_req && !busy && (($urandom % 100) < gnt_pct);
    imem_rvalid = busy && (cnt == 0);
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;

    hold_prev = 0;
    if (rs) begin
      model_pc  = RV;
      halted    = 0;
      exp_reset = 1;
    end else begin
      if (imem_gnt) begin
        chk("gnt_addr", imem_addr, model_pc);
        last_gnt = imem_addr;
        ngnt++;
      end
      if (!halted && redir) begin
        if (tgt[1:0] != 2'b00) begin
          exp_mis = 1;
          halted  = 1;
        end else begin
          model_pc = tgt;
        end
      end else if (!halted && if_valid && if_ready) begin
        chk("if_pc", if_pc, model_pc);
        chk("if_instr", if_instr, mem_word(model_pc));
        chk("if_pc_plus4", if_pc_plus4, model_pc + 32'd4);
        last_pc    = if_pc;
        last_plus4 = if_pc_plus4;
        model_pc   = model_pc + 32'd4;
        ndeliv++;
      end else if (!halted && if_valid) begin
        hold_prev  = 1;
        prev_pc    = if_pc;
        prev_instr = if_instr;
      end
    end

    if (imem_rvalid) busy = 0;
    else if (busy) cnt--;
    if (imem_gnt) begin
      busy     = 1;
      mem_addr = imem_addr;
      cnt      = $urandom_range(lat_max, lat_min) - 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int t = ndeliv + n;
    for (int i = 0; i < budget && ndeliv < t; i++) step(0, 32'h0, 0);
    chk("deliv_reached", {31'h0, ndeliv >= t}, 32'h1);
  endtask

  task automatic wait_gnt(input int budget);
    int t = ngnt + 1;
    for (int i = 0; i < budget && ngnt < t; i++) step(0, 32'h0, 0);
    chk("gnt_reached", {31'h0, ngnt >= t}, 32'h1);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && !busy; i++) step(0, 32'h0, 0);
    chk("busy_reached", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !if_valid; i++) step(0, 32'h0, 0);
    chk("valid_reached", {31'h0, if_valid}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int mis, g0, d0, r;
    logic [31:0] tgt;
    rst = 1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_target = 0; if_ready = 1;
    @(negedge clk);

    // in-order fetch with 1-cycle memory
    step(0, 32'h0, 1);
    step(0, 32'h0, 1);
    wait_deliv(2, 40);

    // downstream stall on the instruction at 0x8
    if_ready = 0;
    wait_valid(20);
    chk("stall_pc", if_pc, 32'h8);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0);
    chk("stall_pc_end", if_pc, 32'h8);
    chk("stall_no_req", {31'h0, imem_req}, 32'h0);
    if_ready = 1;
    wait_deliv(2, 40);
    chk("after_stall", last_pc, 32'hC);

    // redirect while waiting on the slow response for 0x10
    lat_min = 4; lat_max = 4;
    wait_busy(20);
    chk("wait_addr", mem_addr, 32'h10);
    step(1, 32'h100, 0);
    wait_gnt(20);
    chk("redir_gnt", last_gnt, 32'h100);
    wait_deliv(1, 40);
    chk("redir_pc", last_pc, 32'h100);

    // redirect in HOLD with if_ready high on the same cycle
    lat_min = 1; lat_max = 1;
    if_ready = 0;
    wait_valid(20);
    if_ready = 1;
    step(1, 32'h200, 0);
    chk("flush_valid", {31'h0, if_valid}, 32'h0);
    wait_gnt(20);
    chk("flush_gnt", last_gnt, 32'h200);
    wait_deliv(1, 40);
    chk("flush_pc", last_pc, 32'h200);

    // misaligned redirect while a response is outstanding
    lat_min = 3; lat_max = 3;
    wait_busy(20);
    step(1, 32'h102, 0);
    mis = misalign_err;
    g0 = ngnt;
    for (int i = 0; i < 12; i++) begin
      step(0, 32'h0, 0);
      mis += misalign_err;
    end
    chk("mis_pulses", mis, 1);
    chk("halt_gnts", ngnt - g0, 0);
    lat_min = 1; lat_max = 1;
    step(0, 32'h0, 1);
    wait_deliv(1, 40);
    chk("post_halt_pc", last_pc, RV);

    // 32-bit PC wrap, then reset in the middle of a slow fetch
    step(1, 32'hFFFF_FFFC, 0);
    wait_deliv(1, 40);
    chk("wrap_pc", last_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", last_plus4, 32'h0);
    wait_gnt(20);
    chk("wrap_next", last_gnt, 32'h0);
    wait_deliv(1, 40);
    lat_min = 6; lat_max = 6;
    wait_gnt(20);
    chk("slow_gnt", last_gnt, 32'h4);
    step(0, 32'h0, 1);
    step(0, 32'h0, 1);
    lat_min = 1; lat_max = 1;
    wait_deliv(1, 60);
    chk("rst_wait_pc", last_pc, RV);

    // random traffic: grant/latency/stall jitter, redirects, misaligns, resets
    rdy_rand = 1; gnt_pct = 70; lat_min = 1; lat_max = 4;
    d0 = ndeliv;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom % 1000;
      tgt = $urandom & 32'hFFFF_FFFC;
      if (r < 6) step(0, 32'h0, 1);
      else if (r < 20) step(1, 32'hFFFF_FFF0 | (tgt & 32'hC), 0);
      else if (r < 46) step(1, tgt, 0);
      else if (r < 49) step(1, tgt | 32'h2, 0);
      else step(0, 32'h0, 0);
    end
    rdy_rand = 0; if_ready = 1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    step(0, 32'h0, 1);
    wait_deliv(3, 60);
    chk("rand_deliveries", {31'h0, (ndeliv - d0) > 100}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
